// File: rtl/cam_ternary_search.sv
// Ternary CAM with encoded-address maintenance, a two-stage search pipeline,
// a priority-encoded match result and a first-free-entry allocation hint.
// Each entry holds a word, a per-entry don't-care mask and a valid bit.
// A search sampled on edge N is compared against the contents held before
// edge N. Its result is registered on edge N+1.
module cam_ternary_search #(
    parameter int CAM_WIDTH  = 8,
    parameter int CAM_DEPTH  = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [CAM_WIDTH-1:0]  wr_data,
    input  logic [CAM_WIDTH-1:0]  wr_mask,
    input  logic                  inv,
    input  logic                  clear_all,
    input  logic                  search_valid,
    input  logic [CAM_WIDTH-1:0]  search_word,
    input  logic [CAM_WIDTH-1:0]  dont_care_mask,
    output logic                  result_valid,
    output logic                  match_found,
    output logic                  multi_match,
    output logic [ADDR_WIDTH-1:0] match_addr,
    output logic [CAM_DEPTH-1:0]  match_vector,
    output logic [ADDR_WIDTH-1:0] free_addr,
    output logic                  full
);

    // Entry storage. Every entry is compared in parallel, so it is held in flops.
    logic [CAM_WIDTH-1:0]  word_q [CAM_DEPTH];
    logic [CAM_WIDTH-1:0]  word_d [CAM_DEPTH];
    logic [CAM_WIDTH-1:0]  mask_q [CAM_DEPTH];
    logic [CAM_WIDTH-1:0]  mask_d [CAM_DEPTH];
    logic [CAM_DEPTH-1:0]  valid_q;
    logic [CAM_DEPTH-1:0]  valid_d;

    // Per-entry address decode and combinational compare against the current contents.
    logic [CAM_DEPTH-1:0]  wr_sel;
    logic [CAM_DEPTH-1:0]  inv_sel;
    logic [CAM_DEPTH-1:0]  hit;

    // Stage 1: the raw match vector.
    logic                  s1_valid_q;
    logic                  s1_valid_d;
    logic [CAM_DEPTH-1:0]  s1_vec_q;
    logic [CAM_DEPTH-1:0]  s1_vec_d;

    // Stage 2: the registered result fields.
    logic                  res_valid_q;
    logic                  res_valid_d;
    logic [CAM_DEPTH-1:0]  res_vec_q;
    logic [CAM_DEPTH-1:0]  res_vec_d;
    logic                  res_found_q;
    logic                  res_found_d;
    logic                  res_multi_q;
    logic                  res_multi_d;
    logic [ADDR_WIDTH-1:0] res_addr_q;
    logic [ADDR_WIDTH-1:0] res_addr_d;
    logic                  seen_one;

    // Allocation status, registered from the valid bits.
    logic [ADDR_WIDTH-1:0] free_addr_q;
    logic [ADDR_WIDTH-1:0] free_addr_d;
    logic                  full_q;
    logic                  full_d;

    // An address at or above CAM_DEPTH decodes to no entry, so we and inv
    // for such an address do nothing.
    // A bit matches when the stored bit equals the key bit, or when the
    // entry mask or the global mask ignores that bit.
    generate
        for (genvar gi = 0; gi < CAM_DEPTH; gi++) begin : g_entry
            assign wr_sel[gi]  = we  && (wr_addr == ADDR_WIDTH'(gi));
            assign inv_sel[gi] = inv && (wr_addr == ADDR_WIDTH'(gi));
            assign hit[gi]     = valid_q[gi] &
                                 (&(~(word_q[gi] ^ search_word) | mask_q[gi] | dont_care_mask));
        end
    endgenerate

    // Entry update. clear_all has the highest priority, then we, then inv.
    // A write inside a clear_all cycle still leaves its entry valid.
    always_comb begin
        word_d  = word_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        if (clear_all) begin
            valid_d = '0;
        end
        for (int i = 0; i < CAM_DEPTH; i++) begin
            if (wr_sel[i]) begin
                word_d[i]  = wr_data;
                mask_d[i]  = wr_mask;
                valid_d[i] = 1'b1;
            end else if (inv_sel[i] && !clear_all) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // Stage 1 captures the compare result of the current request.
    always_comb begin
        s1_valid_d = search_valid;
        s1_vec_d   = search_valid ? hit : s1_vec_q;
    end

    // Stage 2 reduces the vector. The fields hold their values while no result is due.
    always_comb begin
        res_valid_d = s1_valid_q;
        res_vec_d   = res_vec_q;
        res_found_d = res_found_q;
        res_multi_d = res_multi_q;
        res_addr_d  = res_addr_q;
        seen_one    = 1'b0;
        if (s1_valid_q) begin
            res_vec_d   = s1_vec_q;
            res_found_d = |s1_vec_q;
            res_multi_d = 1'b0;
            res_addr_d  = '0;
            for (int i = 0; i < CAM_DEPTH; i++) begin
                if (s1_vec_q[i]) begin
                    if (seen_one) begin
                        res_multi_d = 1'b1;
                    end else begin
                        res_addr_d = ADDR_WIDTH'(i);
                    end
                    seen_one = 1'b1;
                end
            end
        end
    end

    // Lowest invalid entry wins. The value is 0 when every entry is valid.
    always_comb begin
        full_d      = &valid_q;
        free_addr_d = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_addr_d = ADDR_WIDTH'(i);
            end
        end
    end

    // State registers. Reset also drops any search that is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CAM_DEPTH; i++) begin
                word_q[i] <= '0;
                mask_q[i] <= '0;
            end
            valid_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_vec_q    <= '0;
            res_valid_q <= 1'b0;
            res_vec_q   <= '0;
            res_found_q <= 1'b0;
            res_multi_q <= 1'b0;
            res_addr_q  <= '0;
            free_addr_q <= '0;
            full_q      <= 1'b0;
        end else begin
            for (int i = 0; i < CAM_DEPTH; i++) begin
                word_q[i] <= word_d[i];
                mask_q[i] <= mask_d[i];
            end
            valid_q     <= valid_d;
            s1_valid_q  <= s1_valid_d;
            s1_vec_q    <= s1_vec_d;
            res_valid_q <= res_valid_d;
            res_vec_q   <= res_vec_d;
            res_found_q <= res_found_d;
            res_multi_q <= res_multi_d;
            res_addr_q  <= res_addr_d;
            free_addr_q <= free_addr_d;
            full_q      <= full_d;
        end
    end

    assign result_valid = res_valid_q;
    assign match_found  = res_found_q;
    assign multi_match  = res_multi_q;
    assign match_addr   = res_addr_q;
    assign match_vector = res_vec_q;
    assign free_addr    = free_addr_q;
    assign full         = full_q;

endmodule

// File: tb/tb_cam_ternary_search.sv
// Testbench for cam_ternary_search. A behavioural model with a queue of
// pending results checks every cycle. Table vectors and hand sequences
// check fixed expected values.
module tb_cam_ternary_search;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] wr_mask = '0;
    logic       inv = 1'b0;
    logic       clear_all = 1'b0;
    logic       search_valid = 1'b0;
    logic [7:0] search_word = '0;
    logic [7:0] dont_care_mask = '0;
    logic       result_valid;
    logic       match_found;
    logic       multi_match;
    logic [1:0] match_addr;
    logic [3:0] match_vector;
    logic [1:0] free_addr;
    logic       full;

    cam_ternary_search #(.CAM_WIDTH(8), .CAM_DEPTH(4), .ADDR_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .inv(inv), .clear_all(clear_all),
        .search_valid(search_valid), .search_word(search_word),
        .dont_care_mask(dont_care_mask), .result_valid(result_valid),
        .match_found(match_found), .multi_match(multi_match),
        .match_addr(match_addr), .match_vector(match_vector),
        .free_addr(free_addr), .full(full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: the entry contents and a queue of results still due.
    logic [7:0] m_word [4];
    logic [7:0] m_mask [4];
    logic [3:0] m_valid = '0;
    typedef struct { int due; logic [3:0] vec; } pend_t;
    pend_t pq[$];
    logic       e_rv, e_found, e_multi, e_full;
    logic [3:0] e_vec;
    logic [1:0] e_addr, e_free;

    typedef struct {
        logic [7:0] key;
        logic [7:0] dcm;
        logic [3:0] vec;
        logic [1:0] addr;
        logic       found;
        logic       multi;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic logic [3:0] model_match(input logic [7:0] key, input logic [7:0] dcm);
        logic [3:0] v = '0;
        for (int i = 0; i < 4; i++)
            v[i] = m_valid[i] && (((m_word[i] ^ key) & ~(m_mask[i] | dcm)) == 8'h00);
        return v;
    endfunction

    // Advance one clock, update the model with the inputs just sampled, and check all outputs.
    task automatic tick();
        logic [3:0] v;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_valid = '0;
            for (int i = 0; i < 4; i++) begin m_word[i] = '0; m_mask[i] = '0; end
            pq.delete();
            e_vec = '0; e_found = 0; e_multi = 0; e_addr = '0; e_full = 0; e_free = '0;
        end else begin
            e_full = &m_valid;
            e_free = lowest_set(~m_valid);
            if (search_valid) pq.push_back('{cyc + 1, model_match(search_word, dont_care_mask)});
            if (clear_all) m_valid = '0;
            if (we) begin
                m_word[wr_addr] = wr_data; m_mask[wr_addr] = wr_mask; m_valid[wr_addr] = 1'b1;
            end else if (inv) begin
                m_valid[wr_addr] = 1'b0;
            end
        end
        e_rv = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            v = pq[0].vec;
            void'(pq.pop_front());
            e_rv = 1'b1; e_vec = v; e_found = |v;
            e_multi = ($countones(v) >= 2); e_addr = lowest_set(v);
        end
        chk("result_valid", result_valid, e_rv);
        chk("match_vector", match_vector, e_vec);
        chk("match_found", match_found, e_found);
        chk("multi_match", multi_match, e_multi);
        chk("match_addr", match_addr, e_addr);
        chk("full", full, e_full);
        chk("free_addr", free_addr, e_free);
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d, input logic [7:0] m);
        we = 1; wr_addr = a; wr_data = d; wr_mask = m;
        tick();
        we = 0;
    endtask

    task automatic search(input logic [7:0] key, input logic [7:0] dcm);
        search_valid = 1; search_word = key; dont_care_mask = dcm;
        tick();
        search_valid = 0;
        tick();
    endtask

    initial begin
        tbl[0] = '{8'h3C, 8'h00, 4'b0101, 2'd0, 1'b1, 1'b1};
        tbl[1] = '{8'h3D, 8'h00, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[2] = '{8'h3C, 8'hFF, 4'b0101, 2'd0, 1'b1, 1'b1};
        tbl[3] = '{8'hA5, 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[4] = '{8'h7C, 8'h40, 4'b0101, 2'd0, 1'b1, 1'b1};
        tbl[5] = '{8'h2C, 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[6] = '{8'h2C, 8'h10, 4'b0101, 2'd0, 1'b1, 1'b1};

        // Reset state
        tick(); tick();
        chk("rst_result_valid", result_valid, 0);
        chk("rst_match_vector", match_vector, 0);
        chk("rst_full", full, 0);
        chk("rst_free_addr", free_addr, 0);
        rst = 0;
        tick();

        // Search an empty CAM. The pulse comes two cycles after the request and lasts one cycle.
        search_valid = 1; search_word = 8'hA5;
        tick();
        search_valid = 0;
        chk("empty_rv_early", result_valid, 0);
        tick();
        chk("empty_rv", result_valid, 1);
        chk("empty_found", match_found, 0);
        chk("empty_vec", match_vector, 0);
        chk("empty_full", full, 0);
        chk("empty_free", free_addr, 0);
        tick();
        chk("empty_rv_pulse", result_valid, 0);

        // Single exact entry
        write(2'd2, 8'h3C, 8'h00);
        search(8'h3C, 8'h00);
        chk("e2_addr", match_addr, 2);
        chk("e2_vec", match_vector, 4'b0100);
        chk("e2_multi", multi_match, 0);
        search(8'h3D, 8'h00);
        chk("e2_miss_found", match_found, 0);

        // Table vectors with entry0 = 30/0F and entry2 = 3C/00
        write(2'd0, 8'h30, 8'h0F);
        for (int i = 0; i < 7; i++) begin
            search(tbl[i].key, tbl[i].dcm);
            $display("tbl[%0d] key=%h dcm=%h vec=%b addr=%0d found=%0d multi=%0d",
                     i, tbl[i].key, tbl[i].dcm, match_vector, match_addr, match_found, multi_match);
            chk("tbl_vec", match_vector, tbl[i].vec);
            chk("tbl_addr", match_addr, tbl[i].addr);
            chk("tbl_found", match_found, tbl[i].found);
            chk("tbl_multi", multi_match, tbl[i].multi);
        end

        // inv in the same cycle as a search does not affect that search
        search_valid = 1; search_word = 8'h3C; dont_care_mask = 8'h00;
        inv = 1; wr_addr = 2'd2;
        tick();
        search_valid = 0; inv = 0;
        tick();
        chk("inv_same_vec", match_vector, 4'b0101);
        search(8'h3C, 8'h00);
        chk("inv_after_vec", match_vector, 4'b0001);

        // Fill, invalidate, then clear_all together with a write
        for (int i = 0; i < 4; i++) write(2'(i), 8'h40 + 8'(i), 8'h00);
        chk("fill_full_lag", full, 0);
        tick();
        chk("fill_full", full, 1);
        chk("fill_free", free_addr, 0);
        inv = 1; wr_addr = 2'd1;
        tick();
        inv = 0;
        tick();
        chk("inv1_full", full, 0);
        chk("inv1_free", free_addr, 1);
        clear_all = 1;
        write(2'd3, 8'h77, 8'h00);
        clear_all = 0;
        tick();
        chk("clr_free", free_addr, 0);
        chk("clr_full", full, 0);
        search(8'h77, 8'h00);
        chk("clr_vec", match_vector, 4'b1000);

        // Back-to-back searches, with reset killing the last one in flight
        clear_all = 1;
        write(2'd0, 8'h30, 8'h00);
        clear_all = 0;
        write(2'd2, 8'h3C, 8'h00);
        search_valid = 1; search_word = 8'h3C; tick();
        search_word = 8'h55; tick();
        chk("pipe_rv1", result_valid, 1);
        chk("pipe_vec1", match_vector, 4'b0100);
        search_word = 8'h30; tick();
        chk("pipe_rv2", result_valid, 1);
        chk("pipe_found2", match_found, 0);
        search_word = 8'h3C; tick();
        chk("pipe_rv3", result_valid, 1);
        chk("pipe_vec3", match_vector, 4'b0001);
        search_valid = 0; rst = 1; tick();
        chk("pipe_rv4_killed", result_valid, 0);
        rst = 0; tick();
        chk("pipe_rv4_none", result_valid, 0);
        tick();

        // Random traffic checked against the model
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 63) == 0);
            clear_all      = ($urandom_range(0, 31) == 0);
            we             = ($urandom_range(0, 2) == 0);
            inv            = ($urandom_range(0, 3) == 0);
            wr_addr        = 2'($urandom_range(0, 3));
            wr_data        = {4'h3, 4'($urandom_range(0, 15))};
            wr_mask        = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'h0F) : 8'h00;
            search_valid   = 1'($urandom_range(0, 1));
            search_word    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h3, 4'($urandom_range(0, 15))};
            dont_care_mask = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            tick();
        end
        rst = 0; we = 0; inv = 0; clear_all = 0; search_valid = 0;
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
